// File: rtl/tip_hello_reset_pkg.sv
// Shared state encoding and widths for the TIP_HELLO reset sequencer.
package tip_hello_reset_pkg;

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StRelSys   = 3'd2,
        StRelDram  = 3'd3,
        StRun      = 3'd4
    } seq_state_e;

    localparam int unsigned RetryWidth = 4;
    localparam logic [RetryWidth-1:0] RetryMax = '1;

endpackage

// File: rtl/tip_hello_sync_2ff.sv
// Two-flop synchronizer with synchronous active-low reset to 0.
module tip_hello_sync_2ff (
    input  logic clk_i,
    input  logic rstnn_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/tip_hello_reset_sequencer.sv
// PLL reset / lock qualification / ordered reset release for the TIP_HELLO clock stage.
// Optional lock timeout and retry counting under `TIP_HELLO_RESET_SEQ_TIMEOUT_EN.
module tip_hello_reset_sequencer
    import tip_hello_reset_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 8,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned DRAM_DELAY_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH           = 17
) (
    input  logic                  clk_i,
    input  logic                  rstnn_i,
    input  logic                  pll_locked_i,
    input  logic                  dram_present_i,
    input  logic                  sw_reset_req_i,
    input  logic                  lock_lost_clr_i,
    output logic                  pll_reset_o,
    output logic                  rstnn_system_o,
    output logic                  rstnn_dram_o,
    output logic                  seq_done_o,
    output logic                  lock_lost_o,
    output logic [RetryWidth-1:0] retry_count_o
);

    if ((((PLL_RST_CYCLES | LOCK_STABLE_CYCLES | DRAM_DELAY_CYCLES | LOCK_TIMEOUT_CYCLES)
          >> CNT_WIDTH) != 0) || (PLL_RST_CYCLES == 0) || (LOCK_STABLE_CYCLES == 0) ||
        (DRAM_DELAY_CYCLES == 0)) begin : gen_param_chk
        $error("tip_hello_reset_sequencer: cycle parameters out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] PllLast    = CNT_WIDTH'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] StableLast = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DramLast   = CNT_WIDTH'(DRAM_DELAY_CYCLES - 1);

    logic                 locked_s;
    seq_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 set_lost;
    logic                 pll_reset_q, rstnn_system_q, rstnn_dram_q, seq_done_q, lock_lost_q;

`ifdef TIP_HELLO_RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    logic [CNT_WIDTH-1:0]  tcnt_q, tcnt_d;
    logic                  timeout;
    logic [RetryWidth-1:0] retry_q;
`endif

    tip_hello_sync_2ff u_lock_sync (
        .clk_i   (clk_i),
        .rstnn_i (rstnn_i),
        .d_i     (pll_locked_i),
        .q_o     (locked_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        set_lost = 1'b0;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == PllLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRelSys;
                end
            end
            StRelSys: begin
                if (!locked_s) begin
                    state_d = StPllRst;
                end else if (cnt_q == DramLast) begin
                    state_d = dram_present_i ? StRelDram : StRun;
                end
            end
            StRelDram: begin
                state_d = locked_s ? StRun : StPllRst;
            end
            StRun: begin
                cnt_d = '0;
                // Lock loss dominates a coincident software request so it is still flagged.
                if (!locked_s) begin
                    state_d  = StPllRst;
                    set_lost = 1'b1;
                end else if (sw_reset_req_i) begin
                    state_d = StPllRst;
                end
            end
            default: state_d = StPllRst;
        endcase
`ifdef TIP_HELLO_RESET_SEQ_TIMEOUT_EN
        // A release in the final timeout cycle wins over the retry.
        timeout = (state_q == StWaitLock) && (state_d == StWaitLock) && (tcnt_q == TimeoutLast);
        if (timeout) state_d = StPllRst;
        tcnt_d = ((state_q == StWaitLock) && (state_d == StWaitLock)) ?
                 tcnt_q + CNT_WIDTH'(1) : '0;
`endif
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change in the same cycle as the state.
    always_ff @(posedge clk_i) begin
        if (!rstnn_i) begin
            state_q        <= StPllRst;
            cnt_q          <= '0;
            pll_reset_q    <= 1'b1;
            rstnn_system_q <= 1'b0;
            rstnn_dram_q   <= 1'b0;
            seq_done_q     <= 1'b0;
            lock_lost_q    <= 1'b0;
`ifdef TIP_HELLO_RESET_SEQ_TIMEOUT_EN
            tcnt_q         <= '0;
            retry_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pll_reset_q    <= (state_d == StPllRst);
            rstnn_system_q <= state_d inside {StRelSys, StRelDram, StRun};
            rstnn_dram_q   <= dram_present_i && (state_d inside {StRelDram, StRun});
            seq_done_q     <= (state_d == StRun);
            lock_lost_q    <= set_lost | (lock_lost_q & ~lock_lost_clr_i);
`ifdef TIP_HELLO_RESET_SEQ_TIMEOUT_EN
            tcnt_q         <= tcnt_d;
            if (timeout && (retry_q != RetryMax)) retry_q <= retry_q + RetryWidth'(1);
`endif
        end
    end

    assign pll_reset_o    = pll_reset_q;
    assign rstnn_system_o = rstnn_system_q;
    assign rstnn_dram_o   = rstnn_dram_q;
    assign seq_done_o     = seq_done_q;
    assign lock_lost_o    = lock_lost_q;
`ifdef TIP_HELLO_RESET_SEQ_TIMEOUT_EN
    assign retry_count_o  = retry_q;
`else
    assign retry_count_o  = '0;
`endif

endmodule
